// File: rtl/bus_glue_if.sv
// CPU-side 68000 bus bundle between the CPU model and the bus glue.
// The master modport drives address and strobes; the slave modport (the
// glue) drives chip selects, read/write enables and cycle terminations.
interface bus_glue_if #(
    parameter int NUM_CS = 3
);
    logic [23:0]       logaddr;
    logic              as_n;
    logic              uds_n;
    logic              lds_n;
    logic              w_n;
    logic [2:0]        fc;
    logic [NUM_CS-1:0] cs_n;
    logic              re_n;
    logic              we_n;
    logic              dtack_n;
    logic              avec_n;
    logic              berr_n;

    modport master (
        output logaddr, as_n, uds_n, lds_n, w_n, fc,
        input  cs_n, re_n, we_n, dtack_n, avec_n, berr_n
    );

    modport slave (
        input  logaddr, as_n, uds_n, lds_n, w_n, fc,
        output cs_n, re_n, we_n, dtack_n, avec_n, berr_n
    );
endinterface

// File: rtl/bus_glue.sv
// Synchronous 68000 bus glue: CPU clock divider, power-on reset sequencer,
// chip-select decode with per-region wait states, autovector acknowledge
// and bus-error watchdog. Everything runs on i_sysclk with a synchronous
// active-low reset.
// Optional macro BUS_GLUE_DMA_EN adds bus arbitration (dma_req/dma_gnt,
// br_n/bg_n) with a GRANT state that locks the CPU strobes out.
//
// state | meaning
// IDLE  | no cycle; decode a qualified strobe
// WAIT  | region selected, counting down wait states
// TMO   | unclaimed address, counting down to bus error
// ACK   | dtack_n asserted until as_n rises
// IACK  | avec_n asserted until as_n rises
// ERR   | berr_n asserted until as_n rises
// GRANT | bus handed to DMA (BUS_GLUE_DMA_EN only)
module bus_glue #(
    parameter int                        CLK_DIV      = 2,
    parameter int                        NUM_CS       = 3,
    parameter logic [4*NUM_CS-1:0]       CS_BASE      = 12'h210,
    parameter int                        WAIT_BITS    = 4,
    parameter logic [WAIT_BITS*NUM_CS-1:0] CS_WAIT    = 12'h002,
    parameter int                        BERR_TIMEOUT = 64,
    parameter int                        RESET_CYCLES = 1024
) (
    input  logic       i_sysclk,
    input  logic       i_sysrst_n,
    output logic       o_cpuclk,
    output logic       o_cpurst_n,
    output logic       o_halt_n,
`ifdef BUS_GLUE_DMA_EN
    input  logic       i_dma_req,
    output logic       o_dma_gnt,
    output logic       o_br_n,
    input  logic       i_bg_n,
`endif
    bus_glue_if.slave  bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int RST_W = $clog2(RESET_CYCLES + 1);
    localparam int TMO_W = $clog2(BERR_TIMEOUT + 1);
    localparam int CNT_W = (WAIT_BITS > TMO_W) ? WAIT_BITS : TMO_W;
    localparam int IDX_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_WAIT, ST_TMO, ST_ACK, ST_IACK, ST_ERR, ST_GRANT
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_div;
    logic               r_cpuclk;
    logic [RST_W-1:0]   r_rst_cnt;
    logic               r_cpurst_n;
    logic               r_as_n, r_uds_n, r_lds_n, r_w_n;
    logic [2:0]         r_fc;
    logic [3:0]         r_tag;
    logic [CNT_W-1:0]   r_cnt;
    logic [NUM_CS-1:0]  r_cs_n;
    logic               r_re_n, r_we_n, r_dtack_n, r_avec_n, r_berr_n;
    logic               w_start, w_release, w_hit;
    logic [IDX_W-1:0]   w_idx;
    logic [WAIT_BITS-1:0] w_wait;
    logic               w_unused;
`ifdef BUS_GLUE_DMA_EN
    logic               r_dma_req, r_bg_n, r_br_n, r_dma_gnt;
`endif

    // Only the region tag of the address takes part in decode.
    assign w_unused = ^bus.logaddr[19:0];

    // Free-running CPU clock divider, toggling every CLK_DIV edges.
    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst_n) begin
            r_div    <= '0;
            r_cpuclk <= 1'b0;
        end else if (r_div == DIV_W'(CLK_DIV - 1)) begin
            r_div    <= '0;
            r_cpuclk <= ~r_cpuclk;
        end else begin
            r_div    <= r_div + 1'b1;
        end
    end

    // Power-on sequencer: CPU reset/halt held low for RESET_CYCLES edges.
    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst_n) begin
            r_rst_cnt  <= '0;
            r_cpurst_n <= 1'b0;
        end else begin
            if (r_rst_cnt != RST_W'(RESET_CYCLES))
                r_rst_cnt <= r_rst_cnt + 1'b1;
            r_cpurst_n <= (r_rst_cnt == RST_W'(RESET_CYCLES));
        end
    end

    // Single input register stage for all CPU-side controls.
    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst_n) begin
            r_as_n  <= 1'b1;
            r_uds_n <= 1'b1;
            r_lds_n <= 1'b1;
            r_w_n   <= 1'b1;
            r_fc    <= '0;
            r_tag   <= '0;
`ifdef BUS_GLUE_DMA_EN
            r_dma_req <= 1'b0;
            r_bg_n    <= 1'b1;
`endif
        end else begin
            r_as_n  <= bus.as_n;
            r_uds_n <= bus.uds_n;
            r_lds_n <= bus.lds_n;
            r_w_n   <= bus.w_n;
            r_fc    <= bus.fc;
            r_tag   <= bus.logaddr[23:20];
`ifdef BUS_GLUE_DMA_EN
            r_dma_req <= i_dma_req;
            r_bg_n    <= i_bg_n;
`endif
        end
    end

    // Region decode; scanning downward lets the lowest matching index win.
    always_comb begin
        w_hit  = 1'b0;
        w_idx  = '0;
        w_wait = '0;
        for (int i = NUM_CS - 1; i >= 0; i--) begin
            if (r_tag == CS_BASE[4*i +: 4]) begin
                w_hit  = 1'b1;
                w_idx  = IDX_W'(i);
                w_wait = CS_WAIT[i*WAIT_BITS +: WAIT_BITS];
            end
        end
    end

    assign w_start   = !r_as_n && (!r_uds_n || !r_lds_n);
    assign w_release = r_as_n && (r_state == ST_WAIT || r_state == ST_TMO ||
                                  r_state == ST_ACK  || r_state == ST_IACK ||
                                  r_state == ST_ERR);

    // Bus-cycle FSM; as_n rising takes priority over counter expiry.
    always_ff @(posedge i_sysclk) begin
        if (!i_sysrst_n) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_cs_n    <= '1;
            r_re_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_dtack_n <= 1'b1;
            r_avec_n  <= 1'b1;
            r_berr_n  <= 1'b1;
`ifdef BUS_GLUE_DMA_EN
            r_br_n    <= 1'b1;
            r_dma_gnt <= 1'b0;
`endif
        end else if (w_release) begin
            r_state   <= ST_IDLE;
            r_cs_n    <= '1;
            r_re_n    <= 1'b1;
            r_we_n    <= 1'b1;
            r_dtack_n <= 1'b1;
            r_avec_n  <= 1'b1;
            r_berr_n  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
`ifdef BUS_GLUE_DMA_EN
                    r_br_n <= ~r_dma_req;
                    if (r_cpurst_n && !r_br_n && r_dma_req && !r_bg_n && r_as_n) begin
                        r_state   <= ST_GRANT;
                        r_dma_gnt <= 1'b1;
                    end else
`endif
                    if (r_cpurst_n && w_start) begin
                        if (r_fc == 3'b111) begin
                            r_state  <= ST_IACK;
                            r_avec_n <= 1'b0;
                        end else if (w_hit) begin
                            r_state <= ST_WAIT;
                            r_cnt   <= CNT_W'(w_wait);
                            r_cs_n  <= ~(NUM_CS'(1) << w_idx);
                            r_re_n  <= !r_w_n;
                            r_we_n  <= r_w_n;
                        end else begin
                            r_state <= ST_TMO;
                            r_cnt   <= CNT_W'(BERR_TIMEOUT - 1);
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state   <= ST_ACK;
                        r_dtack_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_TMO: begin
                    if (r_cnt == '0) begin
                        r_state  <= ST_ERR;
                        r_berr_n <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef BUS_GLUE_DMA_EN
                ST_GRANT: begin
                    if (!r_dma_req) begin
                        r_state   <= ST_IDLE;
                        r_br_n    <= 1'b1;
                        r_dma_gnt <= 1'b0;
                    end
                end
`endif
                ST_ACK, ST_IACK, ST_ERR: ;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cpuclk    = r_cpuclk;
    assign o_cpurst_n  = r_cpurst_n;
    assign o_halt_n    = r_cpurst_n;
    assign bus.cs_n    = r_cs_n;
    assign bus.re_n    = r_re_n;
    assign bus.we_n    = r_we_n;
    assign bus.dtack_n = r_dtack_n;
    assign bus.avec_n  = r_avec_n;
    assign bus.berr_n  = r_berr_n;
`ifdef BUS_GLUE_DMA_EN
    assign o_br_n      = r_br_n;
    assign o_dma_gnt   = r_dma_gnt;
`endif
endmodule

// File: tb/tb_bus_glue.sv
// Self-checking bench for bus_glue: directed and randomized 68000 bus
// cycles compared against a timing model built from the glue's cycle rules.
// DMA arbitration is exercised when BUS_GLUE_DMA_EN is defined.
module tb_bus_glue;
    localparam int RST_CYC = 16;
    localparam int BERR_TO = 64;
    localparam int CDIV    = 2;

    logic sysclk = 1'b0;
    logic sysrst_n = 1'b0;
    logic cpuclk, cpurst_n, halt_n;
`ifdef BUS_GLUE_DMA_EN
    logic dma_req = 1'b0;
    logic bg_n = 1'b1;
    logic dma_gnt, br_n;
`endif

    int n_chk = 0;
    int n_pass = 0;

    // Region table for the default configuration: tags and wait counts.
    int tags[3]  = '{0, 1, 2};
    int waits[3] = '{2, 0, 0};

    bus_glue_if #(.NUM_CS(3)) bus ();

    bus_glue #(
        .CLK_DIV(CDIV), .NUM_CS(3), .CS_BASE(12'h210), .WAIT_BITS(4),
        .CS_WAIT(12'h002), .BERR_TIMEOUT(BERR_TO), .RESET_CYCLES(RST_CYC)
    ) dut (
        .i_sysclk(sysclk),
        .i_sysrst_n(sysrst_n),
        .o_cpuclk(cpuclk),
        .o_cpurst_n(cpurst_n),
        .o_halt_n(halt_n),
`ifdef BUS_GLUE_DMA_EN
        .i_dma_req(dma_req),
        .o_dma_gnt(dma_gnt),
        .o_br_n(br_n),
        .i_bg_n(bg_n),
`endif
        .bus(bus)
    );

    always #5 sysclk = ~sysclk;

    function automatic logic [7:0] strobes();
        return {bus.cs_n, bus.re_n, bus.we_n, bus.dtack_n, bus.avec_n, bus.berr_n};
    endfunction

    // One CPU cycle: as_n captured at edge N, samples taken after N+j.
    // as_n is driven high after sample j == hold; tail extra samples follow.
    task automatic run_cycle(input logic [23:0] addr, input logic uds, input logic lds,
                             input logic wn, input logic [2:0] fc, input int hold,
                             input int tail, input string name);
        int region = -1;
        int ack_edge = -1;
        int rel;
        logic [7:0] smask = 8'h00;
        logic [7:0] amask = 8'h00;
        logic [7:0] exp_v, got;
        for (int i = 0; i < 3; i++)
            if (region < 0 && int'(addr[23:20]) == tags[i]) region = i;
        if (fc == 3'b111) begin
            smask = 8'b0000_0010;
        end else if (region >= 0) begin
            smask = (8'h20 << region) | (wn ? 8'h10 : 8'h08);
            amask = 8'h04;
            ack_edge = 2 + waits[region];
        end else begin
            amask = 8'h01;
            ack_edge = 1 + BERR_TO;
        end
        rel = hold + 2;
        bus.logaddr = addr; bus.uds_n = uds; bus.lds_n = lds;
        bus.w_n = wn; bus.fc = fc; bus.as_n = 1'b0;
        for (int j = 0; j <= hold + tail; j++) begin
            @(negedge sysclk);
            exp_v = 8'hFF;
            if (j >= 1 && j < rel) exp_v &= ~smask;
            if (ack_edge > 0 && j >= ack_edge && j < rel) exp_v &= ~amask;
            got = strobes();
            n_chk++;
            if (got !== exp_v)
                $display("FAIL %s j=%0d strobes got=%b exp=%b (cs3,re,we,dtack,avec,berr)",
                         name, j, got, exp_v);
            else n_pass++;
            if (j == hold) begin
                bus.as_n = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        logic [10:0] got, exp_v;
        sysrst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge sysclk);
            got = {cpuclk, cpurst_n, halt_n, strobes()};
            n_chk++;
            if (got !== {3'b000, 8'hFF}) $display("FAIL reset_hold k=%0d got=%b exp=%b", k, got, {3'b000, 8'hFF});
            else n_pass++;
        end
        sysrst_n = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge sysclk);
            exp_v = {1'((k / CDIV) % 2), (k > RST_CYC), (k > RST_CYC), 8'hFF};
            got = {cpuclk, cpurst_n, halt_n, strobes()};
            n_chk++;
            if (got !== exp_v) $display("FAIL reset_seq k=%0d got=%b exp=%b", k, got, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_rom_read();
        run_cycle(24'h000100, 1'b0, 1'b1, 1'b1, 3'b110, 6, 2, "rom_read");
    endtask

    task automatic test_write();
        run_cycle(24'h1000FE, 1'b1, 1'b0, 1'b0, 3'b101, 3, 2, "write_cs1");
    endtask

    task automatic test_berr();
        run_cycle(24'hF00000, 1'b0, 1'b0, 1'b1, 3'b110, 67, 2, "berr");
    endtask

    task automatic test_abort();
        run_cycle(24'hF00000, 1'b0, 1'b1, 1'b1, 3'b110, 8, 3, "abort_tmo");
        run_cycle(24'h000200, 1'b0, 1'b1, 1'b1, 3'b110, 1, 2, "abort_wait");
        run_cycle(24'h000200, 1'b0, 1'b1, 1'b1, 3'b110, 2, 3, "race_dtack");
        run_cycle(24'hA00000, 1'b0, 1'b1, 1'b0, 3'b001, 63, 3, "race_berr");
    endtask

    task automatic test_iack();
        run_cycle(24'hFFFFF5, 1'b0, 1'b0, 1'b1, 3'b111, 5, 2, "iack");
    endtask

    task automatic test_unqualified();
        bus.logaddr = 24'h000100; bus.fc = 3'b110; bus.w_n = 1'b1;
        bus.uds_n = 1'b1; bus.lds_n = 1'b1; bus.as_n = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge sysclk);
            n_chk++;
            if (strobes() !== 8'hFF) $display("FAIL unqualified k=%0d got=%b exp=%b", k, strobes(), 8'hFF);
            else n_pass++;
        end
        bus.as_n = 1'b1;
        repeat (2) @(negedge sysclk);
    endtask

    task automatic test_back_to_back();
        run_cycle(24'h000010, 1'b0, 1'b1, 1'b1, 3'b110, 4, 1, "b2b_a");
        run_cycle(24'h200010, 1'b1, 1'b0, 1'b0, 3'b101, 2, 1, "b2b_b");
        run_cycle(24'h100010, 1'b0, 1'b0, 1'b1, 3'b110, 3, 2, "b2b_c");
    endtask

    task automatic test_random();
        logic [23:0] a;
        logic [1:0] ds;
        logic [2:0] f;
        int t, lim;
        for (int n = 0; n < 24; n++) begin
            t = $urandom_range(0, 5);
            if (t > 2) t = $urandom_range(3, 15);
            a = {4'(t), 20'($urandom)};
            ds = 2'($urandom_range(1, 3));
            f = 3'($urandom_range(0, 7));
            lim = (f == 3'b111) ? 4 : (t <= 2) ? 2 + waits[t] + 2 : BERR_TO + 3;
            run_cycle(a, !ds[1], !ds[0], 1'($urandom), f, $urandom_range(0, lim),
                      $urandom_range(1, 3), $sformatf("rand%0d", n));
        end
    endtask

`ifdef BUS_GLUE_DMA_EN
    task automatic test_dma();
        dma_req = 1'b1;
        repeat (2) @(negedge sysclk);
        n_chk++;
        if ({br_n, dma_gnt} !== 2'b00) $display("FAIL dma_req got br_n,gnt=%b exp=00", {br_n, dma_gnt});
        else n_pass++;
        bg_n = 1'b0;
        repeat (2) @(negedge sysclk);
        n_chk++;
        if ({br_n, dma_gnt} !== 2'b01) $display("FAIL dma_grant got br_n,gnt=%b exp=01", {br_n, dma_gnt});
        else n_pass++;
        bus.logaddr = 24'h000100; bus.fc = 3'b110; bus.w_n = 1'b1;
        bus.uds_n = 1'b0; bus.as_n = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge sysclk);
            n_chk++;
            if (strobes() !== 8'hFF) $display("FAIL dma_lockout k=%0d got=%b exp=%b", k, strobes(), 8'hFF);
            else n_pass++;
        end
        bus.as_n = 1'b1; bus.uds_n = 1'b1;
        @(negedge sysclk);
        dma_req = 1'b0; bg_n = 1'b1;
        repeat (2) @(negedge sysclk);
        n_chk++;
        if ({br_n, dma_gnt, strobes()} !== {2'b10, 8'hFF})
            $display("FAIL dma_release got %b exp %b", {br_n, dma_gnt, strobes()}, {2'b10, 8'hFF});
        else n_pass++;
        repeat (2) @(negedge sysclk);
    endtask
`endif

    task automatic test_reset_mid();
        bus.logaddr = 24'h000100; bus.fc = 3'b110; bus.w_n = 1'b1;
        bus.uds_n = 1'b0; bus.lds_n = 1'b1; bus.as_n = 1'b0;
        repeat (3) @(negedge sysclk);
        sysrst_n = 1'b0;
        @(negedge sysclk);
        n_chk++;
        if ({cpuclk, cpurst_n, halt_n, strobes()} !== {3'b000, 8'hFF})
            $display("FAIL reset_mid got=%b exp=%b", {cpuclk, cpurst_n, halt_n, strobes()}, {3'b000, 8'hFF});
        else n_pass++;
        bus.as_n = 1'b1; bus.uds_n = 1'b1;
        sysrst_n = 1'b1;
        repeat (RST_CYC) @(negedge sysclk);
        n_chk++;
        if (cpurst_n !== 1'b0) $display("FAIL reset_restart_low got=%b exp=0", cpurst_n);
        else n_pass++;
        @(negedge sysclk);
        n_chk++;
        if (cpurst_n !== 1'b1) $display("FAIL reset_restart_high got=%b exp=1", cpurst_n);
        else n_pass++;
    endtask

    initial begin
        bus.logaddr = '0; bus.as_n = 1'b1; bus.uds_n = 1'b1; bus.lds_n = 1'b1;
        bus.w_n = 1'b1; bus.fc = 3'b000;
        test_reset();
        test_rom_read();
        test_write();
        test_berr();
        test_abort();
        test_iack();
        test_unqualified();
        test_back_to_back();
        test_random();
`ifdef BUS_GLUE_DMA_EN
        test_dma();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/bus_glue.md
Name: bus_glue

Overview:
- Synchronous 68000 bus glue: CPU clock generation, power-on reset sequencing, parametrised chip-select decode, per-region wait-state DTACK generation, autovector acknowledge and bus-error watchdog.
- Actively drives the CPU-side control pins of the glue device.
- Instantiated inside the glue top level. All logic runs on sysclk.

Parameters:
- CLK_DIV, 2: cpuclk toggles every CLK_DIV sysclk cycles (minimum 1).
- NUM_CS, 3: number of chip-select regions.
- CS_BASE, 12'h210: packed 4-bit region tags; region i matches when logaddr[23:20] == CS_BASE[4i+3:4i]. Default: cs0 = 0x0 (ROM), cs1 = 0x1, cs2 = 0x2.
- WAIT_BITS, 4: width of each wait-state field.
- CS_WAIT, 12'h002: packed WAIT_BITS-wide wait count per region. Default: cs0 = 2, others 0.
- BERR_TIMEOUT, 64: sysclk cycles before an unclaimed cycle gets berr_n.
- RESET_CYCLES, 1024: cpurst_n/halt_n low time after reset.

Ports:
- sysclk  in  1  system clock; only clock.
- sysrst_n  in  1  reset; synchronous, active-low.
- logaddr  in  24  CPU address bus.
- as_n  in  1  address strobe.
- uds_n  in  1  upper data strobe.
- lds_n  in  1  lower data strobe.
- w_n  in  1  read/write (1 = read).
- fc  in  3  function code.
- cpuclk  out  1  CPU clock.
- cpurst_n  out  1  CPU reset.
- halt_n  out  1  CPU halt.
- cs_n  out  NUM_CS  chip selects, one-hot low.
- re_n  out  1  read enable.
- we_n  out  1  write enable.
- dtack_n  out  1  data acknowledge.
- avec_n  out  1  autovector request.
- berr_n  out  1  bus error.

Behaviour:
- Reset (sysrst_n low at an edge):
  - All outputs high except cpuclk = 0, cpurst_n = 0, halt_n = 0.
  - Clock divider, reset counter and FSM cleared; FSM to IDLE.
- Reset sequencer:
  - After release, cpurst_n and halt_n stay low for exactly RESET_CYCLES edges, then go high together and stay high.
  - The FSM is held in IDLE while the sequencer is active.
- cpuclk: free-running from reset release. Toggles on every CLK_DIV-th edge, giving period 2*CLK_DIV sysclk cycles.
- Inputs: as_n, uds_n, lds_n, w_n, fc and logaddr[23:20] are registered once. Edge N is defined as the first edge at which as_n = 0 is captured.
- Cycle start: qualified when registered as_n = 0 and (uds_n = 0 or lds_n = 0).
- IDLE, decode at edge N+1, in priority order:
  - fc == 3'b111 (IACK): go to IACK; avec_n low after edge N+1; no chip select.
  - Region i matches (lowest index wins on multiple matches): go to WAIT and load the counter with CS_WAIT[i].
    - cs_n[i] low.
    - re_n low if w_n = 1, otherwise we_n low.
  - No match: go to TMO and load the counter with BERR_TIMEOUT-1.
- WAIT: each edge, if counter == 0 go to ACK (dtack_n low), else decrement. dtack_n is low after edge N+2+W.
- TMO: decrement; at 0 go to ERR with berr_n low, i.e. after edge N+1+BERR_TIMEOUT.
- ACK / IACK / ERR: hold the asserted strobes until registered as_n = 1, then return to IDLE.
- Release: if registered as_n = 1 at edge M, then after edge M+1 all of cs_n, re_n, we_n, dtack_n, avec_n, berr_n are high.
- Abort: as_n rising while in WAIT or TMO returns to IDLE with the same timing; no dtack_n or berr_n is issued.
- Simultaneous events: as_n rise wins over counter expiry.
- Mutual exclusion: dtack_n, avec_n and berr_n are never low together. At most one cs_n bit is low at any time.
- Back-to-back cycles: a new cycle may start only from IDLE, so there is a minimum of one idle edge between cycles.
- Reset mid-cycle: immediate return to reset values; the sequencer restarts.

Optional Feature:
- Macro BUS_GLUE_DMA_EN. When defined, adds:
  - dma_req  in  1  DMA request.
  - dma_gnt  out  1  DMA grant.
  - br_n  out  1  bus request to CPU.
  - bg_n  in  1  bus grant from CPU.
- Bus-arbitration behaviour:
  - Registered dma_req = 1 in IDLE drives br_n low.
  - When registered bg_n = 0 and as_n = 1, go to GRANT with dma_gnt = 1.
  - Dropping dma_req releases br_n and dma_gnt on the next edge; return to IDLE.
  - Reset values: br_n = 1, dma_gnt = 0.
  - While in GRANT, CPU strobes are ignored and all glue strobes stay high.
- When not defined: the four ports are absent and there is no arbitration logic.

Test Plan:
- Reset with RESET_CYCLES = 16: hold sysrst_n low 3 edges, then release → cpurst_n/halt_n low exactly 16 edges then high; cpuclk period 4 sysclk; all strobes high throughout.
- ROM read at 0x000100 (uds_n = 0, w_n = 1, fc = 3'b110) → cs_n = 3'b110 and re_n = 0 after N+1; dtack_n = 0 after N+4; all high one edge after as_n is seen high.
- Write to 0x1000FE (lds_n = 0, w_n = 0) → cs_n = 3'b101 and we_n = 0 after N+1; dtack_n = 0 after N+2.
- Read at 0xF00000 → no cs_n; berr_n = 0 after N+65; as_n abort at N+10 instead → no berr_n, FSM back to IDLE.
- IACK (fc = 3'b111, logaddr = 0xFFFFF5) → avec_n = 0 after N+1; dtack_n, berr_n and cs_n stay high.
- With BUS_GLUE_DMA_EN: dma_req = 1 → br_n = 0; bg_n = 0 while as_n = 1 → dma_gnt = 1; a CPU as_n pulse during GRANT → no cs_n; dma_req = 0 → br_n = 1 and dma_gnt = 0 the next edge.
